// File: rtl/hex_word_parser_pkg.sv
// Shared definitions for the ASCII hex word parser: delimiter codes,
// parser state encoding and character classification / decode helpers.
package hex_word_parser_pkg;

    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_COMMA = 8'h2C;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCUM   = 2'd1,
        ST_DISCARD = 2'd2
    } state_e;

    function automatic logic ascii_is_delim(input logic [7:0] c);
        return (c == ASCII_LF) || (c == ASCII_CR) ||
               (c == ASCII_SPACE) || (c == ASCII_COMMA);
    endfunction

    function automatic logic ascii_is_hex(input logic [7:0] c);
        return ((c >= 8'h30) && (c <= 8'h39)) ||
               ((c >= 8'h41) && (c <= 8'h46)) ||
               ((c >= 8'h61) && (c <= 8'h66));
    endfunction

    // Only meaningful when ascii_is_hex(c) is true.
    function automatic logic [3:0] ascii_to_nibble(input logic [7:0] c);
        logic [7:0] v;
        v = 8'h00;
        if (c <= 8'h39)      v = c - 8'h30;
        else if (c <= 8'h46) v = c - 8'h37;
        else                 v = c - 8'h57;
        return v[3:0];
    endfunction

endpackage

// File: rtl/hex_word_parser_sync_fifo.sv
// Synchronous FIFO with power-of-two depth; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == (AW+1)'(DEPTH));
    assign do_pop     = pop_i && !empty_o;
    assign do_push    = push_i && (!full_o || do_pop);
    assign pop_data_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/hex_word_parser.sv
// Parses delimited ASCII hex digits from a byte stream into WIDTH-bit words
// and queues them in a small output FIFO.
//
// state      | meaning
// ST_IDLE    | no digits held, waiting for the first digit of a word
// ST_ACCUM   | 1..MAXD digits held in the accumulator
// ST_DISCARD | bad word in progress, skipping to the next delimiter
module hex_word_parser
    import hex_word_parser_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int LSN_FIRST = 1,
    parameter int DEPTH     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic [WIDTH-1:0] word_data,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             err_char,
    output logic             err_overflow,
    output logic             dropped,
    output logic             busy
);

    localparam int MAXD = WIDTH / 4;
    localparam int CW   = $clog2(MAXD + 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] accum_q, accum_d;
    logic             err_char_q, err_char_d;
    logic             err_ovf_q, err_ovf_d;
    logic             dropped_q, dropped_d;
    logic             push;
    logic             is_dig;
    logic             is_delim;
    logic [3:0]       nib;
    logic             fifo_full;
    logic             fifo_empty;

    assign is_dig   = ascii_is_hex(rx_data);
    assign is_delim = ascii_is_delim(rx_data);
    assign nib      = ascii_to_nibble(rx_data);

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        accum_d    = accum_q;
        err_char_d = 1'b0;
        err_ovf_d  = 1'b0;
        push       = 1'b0;
        if (rx_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (is_dig) begin
                        accum_d = WIDTH'(nib);
                        count_d = CW'(1);
                        state_d = ST_ACCUM;
                    end else if (!is_delim) begin
                        err_char_d = 1'b1;
                        state_d    = ST_DISCARD;
                    end
                end
                ST_ACCUM: begin
                    if (is_dig) begin
                        if (count_q == CW'(MAXD)) begin
                            err_ovf_d = 1'b1;
                            count_d   = '0;
                            accum_d   = '0;
                            state_d   = ST_DISCARD;
                        end else begin
                            if (LSN_FIRST != 0)
                                accum_d = accum_q | (WIDTH'(nib) << {count_q, 2'b00});
                            else
                                accum_d = (accum_q << 4) | WIDTH'(nib);
                            count_d = count_q + CW'(1);
                        end
                    end else if (is_delim) begin
                        push    = 1'b1;
                        count_d = '0;
                        state_d = ST_IDLE;
                    end else begin
                        err_char_d = 1'b1;
                        count_d    = '0;
                        accum_d    = '0;
                        state_d    = ST_DISCARD;
                    end
                end
                ST_DISCARD: begin
                    if (is_delim) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // A full FIFO only frees a slot this cycle if the consumer pops.
    assign dropped_d = push && fifo_full && !word_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            accum_q    <= '0;
            err_char_q <= 1'b0;
            err_ovf_q  <= 1'b0;
            dropped_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            accum_q    <= accum_d;
            err_char_q <= err_char_d;
            err_ovf_q  <= err_ovf_d;
            dropped_q  <= dropped_d;
        end
    end

    sync_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .push_data_i(accum_q),
        .pop_i      (word_ready),
        .pop_data_o (word_data),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    assign word_valid   = !fifo_empty;
    assign err_char     = err_char_q;
    assign err_overflow = err_ovf_q;
    assign dropped      = dropped_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_hex_word_parser.sv
// Bench for hex_word_parser: LSN-first and MSN-first instances share one
// byte stream and are compared every cycle against a queue-based model.
module tb_hex_word_parser;

    localparam int W    = 32;
    localparam int D    = 4;
    localparam int MAXD = W / 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [7:0]   rx_data = 8'h00;
    logic         rx_valid = 1'b0;
    logic         word_ready = 1'b0;

    logic [W-1:0] l_data, m_data;
    logic         l_valid, l_char, l_ovf, l_drop, l_busy;
    logic         m_valid, m_char, m_ovf, m_drop, m_busy;

    always #5 clk = ~clk;

    hex_word_parser #(.WIDTH(W), .LSN_FIRST(1), .DEPTH(D)) dut_l (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .word_data(l_data), .word_valid(l_valid), .word_ready(word_ready),
        .err_char(l_char), .err_overflow(l_ovf), .dropped(l_drop), .busy(l_busy));

    hex_word_parser #(.WIDTH(W), .LSN_FIRST(0), .DEPTH(D)) dut_m (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .word_data(m_data), .word_valid(m_valid), .word_ready(word_ready),
        .err_char(m_char), .err_overflow(m_ovf), .dropped(m_drop), .busy(m_busy));

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // 0 = hex digit, 1 = delimiter, 2 = illegal
    function automatic int cls(input logic [7:0] c);
        if ((c >= "0" && c <= "9") || (c >= "a" && c <= "f") || (c >= "A" && c <= "F")) return 0;
        if (c == 8'h0A || c == 8'h0D || c == 8'h20 || c == 8'h2C) return 1;
        return 2;
    endfunction

    function automatic logic [3:0] nib_of(input logic [7:0] c);
        if (c >= "a") return 4'(c - "a" + 10);
        if (c >= "A") return 4'(c - "A" + 10);
        return 4'(c - "0");
    endfunction

    // Behavioural model: digits held as a list, words computed only on delimiter.
    logic [3:0]  digs[$];
    bit          disc;
    logic [31:0] ql[$];
    logic [31:0] qm[$];
    bit          e_char, e_ovf, e_drop;
    bit          armed = 1'b0;

    always @(posedge clk) begin : model
        bit full_b, pop_now, push_now;
        logic [31:0] wl, wm;
        if (rst) begin
            digs.delete(); ql.delete(); qm.delete();
            disc = 0; e_char = 0; e_ovf = 0; e_drop = 0; armed = 1;
        end else begin
            e_char = 0; e_ovf = 0; e_drop = 0;
            full_b   = (ql.size() == D);
            pop_now  = word_ready && (ql.size() > 0);
            push_now = 0;
            wl = 0; wm = 0;
            if (rx_valid) begin
                if (disc) begin
                    if (cls(rx_data) == 1) disc = 0;
                end else if (cls(rx_data) == 0) begin
                    if (digs.size() == MAXD) begin
                        e_ovf = 1; digs.delete(); disc = 1;
                    end else begin
                        digs.push_back(nib_of(rx_data));
                    end
                end else if (cls(rx_data) == 1) begin
                    if (digs.size() > 0) begin
                        push_now = 1;
                        foreach (digs[k]) begin
                            wl = wl | (32'(digs[k]) << (4 * k));
                            wm = (wm << 4) | 32'(digs[k]);
                        end
                        digs.delete();
                    end
                end else begin
                    e_char = 1; digs.delete(); disc = 1;
                end
            end
            if (pop_now) begin
                void'(ql.pop_front());
                void'(qm.pop_front());
            end
            if (push_now) begin
                if (full_b && !pop_now) e_drop = 1;
                else begin
                    ql.push_back(wl);
                    qm.push_back(wm);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("l_valid", l_valid, ql.size() > 0);
            check("m_valid", m_valid, qm.size() > 0);
            if (ql.size() > 0) check("l_data", l_data, ql[0]);
            if (qm.size() > 0) check("m_data", m_data, qm[0]);
            check("l_err_char", l_char, e_char);
            check("m_err_char", m_char, e_char);
            check("l_err_ovf", l_ovf, e_ovf);
            check("m_err_ovf", m_ovf, e_ovf);
            check("l_dropped", l_drop, e_drop);
            check("m_dropped", m_drop, e_drop);
            check("l_busy", l_busy, (digs.size() > 0) || disc);
            check("m_busy", m_busy, (digs.size() > 0) || disc);
        end
    end

    int n_char = 0, n_ovf = 0, n_drop = 0;
    always @(posedge clk) begin
        if (l_char === 1'b1) n_char++;
        if (l_ovf === 1'b1)  n_ovf++;
        if (l_drop === 1'b1) n_drop++;
    end

    task automatic send(input string s);
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            rx_data  = s[i];
            rx_valid = 1'b1;
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        word_ready = 1'b1;
        repeat (D + 1) @(negedge clk);
        word_ready = 1'b0;
    endtask

    task automatic pop_expect(input logic [31:0] exp);
        check("pop_valid", l_valid, 1);
        check("pop_data", l_data, exp);
        word_ready = 1'b1;
        @(negedge clk);
        word_ready = 1'b0;
    endtask

    initial begin
        int base_c, base_o, base_d;
        logic [7:0] c;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", l_valid, 0);
        check("rst_busy", l_busy, 0);
        check("rst_err", {l_char, l_ovf, l_drop}, 0);
        rst = 1'b0;

        send("10\n");
        check("t10_valid", l_valid, 1);
        check("t10_l", l_data, 32'h0000_0001);
        check("t10_m", m_data, 32'h0000_0010);
        drain();

        send("DEADbeef ");
        check("dead_m", m_data, 32'hDEAD_BEEF);
        check("dead_l", l_data, 32'hFEEB_DAED);
        drain();
        send("\r\n");
        idle(1);
        check("crlf_empty", m_valid, 0);

        base_o = n_ovf;
        send("123456789\n");
        idle(1);
        check("ovf_count", n_ovf, base_o + 1);
        check("ovf_noword", l_valid, 0);
        send("5,");
        check("after_ovf", l_data, 32'h0000_0005);
        drain();

        base_c = n_char;
        base_o = n_ovf;
        send("1g3\n7\n");
        idle(1);
        check("char_count", n_char, base_c + 1);
        check("char_noovf", n_ovf, base_o);
        pop_expect(32'h7);
        check("char_empty", l_valid, 0);

        base_d = n_drop;
        send("1 2 3 4 5 ");
        idle(1);
        check("drop_count", n_drop, base_d + 1);
        pop_expect(32'h1); pop_expect(32'h2); pop_expect(32'h3); pop_expect(32'h4);
        check("drop_empty", l_valid, 0);

        send("1 2 3 4 ");
        base_d = n_drop;
        @(negedge clk); rx_data = "6"; rx_valid = 1'b1;
        @(negedge clk); rx_data = " "; word_ready = 1'b1;
        @(negedge clk); rx_valid = 1'b0; word_ready = 1'b0;
        idle(1);
        check("pushpop_nodrop", n_drop, base_d);
        pop_expect(32'h2); pop_expect(32'h3); pop_expect(32'h4); pop_expect(32'h6);
        check("pushpop_empty", l_valid, 0);

        send("12");
        rst = 1'b1; rx_data = "7"; rx_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0; rx_valid = 1'b0;
        check("midrst_busy", l_busy, 0);
        check("midrst_valid", l_valid, 0);
        send("3\n");
        pop_expect(32'h3);
        check("midrst_empty", l_valid, 0);

        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            rst      = ($urandom_range(0, 599) == 0);
            rx_valid = ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 99)) inside
                [0:59]:  c = nib_of("0") + 8'h30 + 8'($urandom_range(0, 9));
                [60:69]: c = 8'h41 + 8'($urandom_range(0, 5));
                [70:79]: c = 8'h61 + 8'($urandom_range(0, 5));
                [80:95]: begin
                    case ($urandom_range(0, 3))
                        0: c = 8'h0A; 1: c = 8'h0D; 2: c = 8'h20; default: c = 8'h2C;
                    endcase
                end
                default: begin
                    c = 8'($urandom_range(0, 255));
                    while (cls(c) != 2) c = 8'($urandom_range(0, 255));
                end
            endcase
            rx_data    = c;
            word_ready = ((i / 200) % 2 == 0) ? ($urandom_range(0, 9) < 6)
                                              : ($urandom_range(0, 9) < 1);
        end
        @(negedge clk);
        rst = 1'b0; rx_valid = 1'b0; word_ready = 1'b1;
        idle(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
